// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: registers EX results, aligns/extends sync-SRAM
// load data, resolves GPR and HI/LO writes. Optional macro: MEM_ADDR_CHECK_EN.
module mem_stage #(
  parameter int EX_TO_MEM_W = 175,
  parameter int MEM_TO_WB_W = 136,
  parameter int MEM_TO_ID_W = 104
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
  input  logic [31:0]            data_sram_rdata,
  output logic [MEM_TO_WB_W-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_W-1:0] mem_to_id_bus,
  output logic                   mem_is_load,
  output logic                   mem_excp_adel
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic [EX_TO_MEM_W-1:0] bus_r;
  logic [31:0]            rdata_hold_r;
  logic                   hold_vld_r;

  logic [1:0]  mt_flag_s;
  logic        flag_s;
  logic [63:0] result_s;
  logic [31:0] inst_s;
  logic [31:0] pc_s;
  logic        dram_en_s;
  logic [3:0]  dram_wen_s;
  logic        sel_rf_res_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] ex_result_s;

  assign {mt_flag_s, flag_s, result_s, inst_s, pc_s, dram_en_s, dram_wen_s,
          sel_rf_res_s, rf_we_s, rf_waddr_s, ex_result_s} = bus_r;

  logic [5:0]  opcode_s;
  logic [1:0]  addr_s;
  logic        is_load_s;
  logic        adel_s;
  logic [31:0] load_src_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_val_s;
  logic [31:0] rf_wdata_s;
  logic        rf_we_out_s;
  logic [1:0]  hilo_we_s;
  logic [1:0]  hilo_we_out_s;
  logic [31:0] hi_wdata_s;
  logic [31:0] lo_wdata_s;
  logic        unused_s;

  assign opcode_s = inst_s[31:26];
  assign addr_s   = ex_result_s[1:0];
  assign unused_s = ^{stall[5], stall[2:0], dram_en_s, dram_wen_s, inst_s[25:0]};

  // Stage register plus capture of load data across a full stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r        <= '0;
      rdata_hold_r <= 32'd0;
      hold_vld_r   <= 1'b0;
    end else begin
      case ({stall[4], stall[3]})
        2'b00, 2'b10: begin
          bus_r      <= ex_to_mem_bus;
          hold_vld_r <= 1'b0;
        end
        2'b01: begin
          bus_r      <= '0;
          hold_vld_r <= 1'b0;
        end
        2'b11: begin
          // SRAM data is only valid on the first MEM cycle, so freeze it there.
          if (is_load_s && !hold_vld_r) begin
            rdata_hold_r <= data_sram_rdata;
            hold_vld_r   <= 1'b1;
          end else begin
            rdata_hold_r <= rdata_hold_r;
            hold_vld_r   <= hold_vld_r;
          end
        end
        default: begin
          bus_r      <= '0;
          hold_vld_r <= 1'b0;
        end
      endcase
    end
  end

  // Load opcode decode.
  always_comb begin
    is_load_s = 1'b0;
    case (opcode_s)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load_s = 1'b1;
      default:                             is_load_s = 1'b0;
    endcase
  end

  // Misaligned access detection.
  always_comb begin
    adel_s = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
    if (dram_en_s) begin
      case (opcode_s)
        OP_LH, OP_LHU, OP_SH: adel_s = addr_s[0];
        OP_LW, OP_SW:         adel_s = (addr_s != 2'd0);
        default:              adel_s = 1'b0;
      endcase
    end else begin
      adel_s = 1'b0;
    end
`else
    adel_s = 1'b0;
`endif
  end

  // Load data alignment and extension.
  always_comb begin
    load_src_s = hold_vld_r ? rdata_hold_r : data_sram_rdata;
    byte_s     = 8'd0;
    half_s     = 16'd0;
    load_val_s = load_src_s;
    case (addr_s)
      2'd0:    byte_s = load_src_s[7:0];
      2'd1:    byte_s = load_src_s[15:8];
      2'd2:    byte_s = load_src_s[23:16];
      2'd3:    byte_s = load_src_s[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr_s[1]) begin
      half_s = load_src_s[31:16];
    end else begin
      half_s = load_src_s[15:0];
    end
    case (opcode_s)
      OP_LB:   load_val_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_val_s = {24'd0, byte_s};
      OP_LH:   load_val_s = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_val_s = {16'd0, half_s};
      OP_LW:   load_val_s = load_src_s;
      default: load_val_s = load_src_s;
    endcase
  end

  // HI/LO write resolution; multiply/divide results take priority over mthi/mtlo.
  always_comb begin
    hilo_we_s  = 2'b00;
    hi_wdata_s = 32'd0;
    lo_wdata_s = 32'd0;
    if (flag_s) begin
      hilo_we_s  = 2'b11;
      hi_wdata_s = result_s[63:32];
      lo_wdata_s = result_s[31:0];
    end else if (mt_flag_s[1]) begin
      hilo_we_s  = 2'b10;
      hi_wdata_s = ex_result_s;
    end else if (mt_flag_s[0]) begin
      hilo_we_s  = 2'b01;
      lo_wdata_s = ex_result_s;
    end else begin
      hilo_we_s = 2'b00;
    end
  end

  assign rf_wdata_s    = sel_rf_res_s ? load_val_s : ex_result_s;
  assign rf_we_out_s   = rf_we_s & ~adel_s;
  assign hilo_we_out_s = hilo_we_s & {2{~adel_s}};

  assign mem_to_wb_bus = {hilo_we_out_s, hi_wdata_s, lo_wdata_s, pc_s,
                          rf_we_out_s, rf_waddr_s, rf_wdata_s};
  assign mem_to_id_bus = {hilo_we_out_s, hi_wdata_s, lo_wdata_s,
                          rf_we_out_s, rf_waddr_s, rf_wdata_s};
  assign mem_is_load   = is_load_s;
  assign mem_excp_adel = adel_s;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, stall/reset sequences,
// and randomized traffic compared against a field-level reference model.
module tb_mem_stage;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SPEC  = 6'h00;

  typedef struct packed {
    logic [1:0]  mt;
    logic        flag;
    logic [63:0] result;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        dram_en;
    logic [3:0]  wen;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] exr;
  } ex_t;

  typedef struct {
    ex_t         ex;
    logic [31:0] rdata;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [1:0]  e_hwe;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [174:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [103:0] mem_to_id_bus;
  logic         mem_is_load;
  logic         mem_excp_adel;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus  (mem_to_wb_bus),
    .mem_to_id_bus  (mem_to_id_bus),
    .mem_is_load    (mem_is_load),
    .mem_excp_adel  (mem_excp_adel)
  );

  always #5 clk = ~clk;

  logic [31:0] o_wdata, o_hi, o_lo;
  logic        o_we;
  logic [1:0]  o_hwe;
  assign o_wdata = mem_to_wb_bus[31:0];
  assign o_we    = mem_to_wb_bus[37];
  assign o_lo    = mem_to_wb_bus[101:70];
  assign o_hi    = mem_to_wb_bus[133:102];
  assign o_hwe   = mem_to_wb_bus[135:134];

  int total = 0;
  int bad = 0;

  // reference model state: instruction currently in MEM and any frozen load word
  ex_t         m_bus;
  logic        m_hv;
  logic [31:0] m_hold;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic ex_t mkex(input logic [5:0] op, input logic [31:0] exr,
                               input logic sel, input logic we,
                               input logic flag = 1'b0, input logic [1:0] mt = 2'b00,
                               input logic [63:0] res = 64'd0);
    ex_t e;
    e.mt = mt; e.flag = flag; e.result = res;
    e.inst = {op, 5'd3, 5'd4, 16'h0010};
    e.pc = 32'hBFC0_0100;
    e.dram_en = (op[5] == 1'b1);
    e.wen = 4'd0;
    e.sel = sel; e.we = we; e.waddr = 5'd8; e.exr = exr;
    return e;
  endfunction

  function automatic logic is_ld(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [31:0] b8, h16;
    int sb, shh;
    sb  = 8 * int'(a);
    shh = 16 * int'(a[1]);
    b8  = w >> sb;
    h16 = w >> shh;
    if (op == OP_LB)  return {{24{b8[7]}}, b8[7:0]};
    if (op == OP_LBU) return {24'd0, b8[7:0]};
    if (op == OP_LH)  return {{16{h16[15]}}, h16[15:0]};
    if (op == OP_LHU) return {16'd0, h16[15:0]};
    return w;
  endfunction

  task automatic model_check(input string tag);
    ex_t b;
    logic [5:0] op;
    logic [1:0] a;
    logic [31:0] ld, wd, hi, lo;
    logic [1:0] hwe;
    logic we, adel;
    b = m_bus;
    op = b.inst[31:26];
    a = b.exr[1:0];
    ld = m_hv ? m_hold : data_sram_rdata;
    adel = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
    adel = b.dram_en && ((((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && a[0]) ||
                         (((op == OP_LW) || (op == OP_SW)) && (a != 2'd0)));
`endif
    wd = b.sel ? extract(op, a, ld) : b.exr;
    hwe = 2'b00; hi = 32'd0; lo = 32'd0;
    if (b.flag) begin
      hwe = 2'b11; hi = b.result[63:32]; lo = b.result[31:0];
    end else if (b.mt[1]) begin
      hwe = 2'b10; hi = b.exr;
    end else if (b.mt[0]) begin
      hwe = 2'b01; lo = b.exr;
    end
    we = b.we & ~adel;
    if (adel) hwe = 2'b00;
    chk({tag, "_wb"}, mem_to_wb_bus, {hwe, hi, lo, b.pc, we, b.waddr, wd});
    chk({tag, "_id"}, {32'd0, mem_to_id_bus}, {32'd0, hwe, hi, lo, we, b.waddr, wd});
    chk({tag, "_isload"}, {135'd0, mem_is_load}, {135'd0, is_ld(op)});
    chk({tag, "_adel"}, {135'd0, mem_excp_adel}, {135'd0, adel});
  endtask

  task automatic model_update();
    if (!stall[3]) begin
      m_bus = ex_t'(ex_to_mem_bus); m_hv = 1'b0;
    end else if (!stall[4]) begin
      m_bus = '0; m_hv = 1'b0;
    end else if (is_ld(m_bus.inst[31:26]) && !m_hv) begin
      m_hold = data_sram_rdata; m_hv = 1'b1;
    end
  endtask

  task automatic apply(input ex_t e, input logic [5:0] st, input logic [31:0] rd,
                       input string tag);
    ex_to_mem_bus = e;
    stall = st;
    data_sram_rdata = rd;
    #4;
    model_check(tag);
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic ex_t rand_ex();
    ex_t e;
    int k;
    k = $urandom_range(0, 10);
    case (k)
      0: e = mkex(OP_LB,  $urandom, 1'b1, 1'b1);
      1: e = mkex(OP_LBU, $urandom, 1'b1, 1'b1);
      2: e = mkex(OP_LH,  $urandom, 1'b1, 1'b1);
      3: e = mkex(OP_LHU, $urandom, 1'b1, 1'b1);
      4: e = mkex(OP_LW,  $urandom, 1'b1, 1'b1);
      5: e = mkex(OP_SH,  $urandom, 1'b0, 1'b0);
      6: e = mkex(OP_SW,  $urandom, 1'b0, 1'b0);
      7: e = mkex(OP_ADDIU, $urandom, 1'b0, 1'b1);
      8: e = mkex(OP_SPEC, $urandom, 1'b0, 1'b0, 1'b1, 2'b00, {$urandom, $urandom});
      9: e = mkex(OP_SPEC, $urandom, 1'b0, 1'b0, 1'b0, 2'($urandom_range(1, 2)));
      default: e = '0;
    endcase
    e.pc = $urandom;
    e.waddr = 5'($urandom);
    if (e.dram_en) e.wen = 4'($urandom);
    return e;
  endfunction

  initial begin
    ex_t nop;
    nop = '0;
    rst = 1'b1;
    stall = 6'd0;
    ex_to_mem_bus = '0;
    data_sram_rdata = 32'd0;
    m_bus = '0; m_hv = 1'b0; m_hold = 32'd0;
    #2;
    model_check("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    vt[0]  = '{mkex(OP_LB,  32'h1003, 1'b1, 1'b1), 32'h80112233, 32'hFFFFFF80, 1'b1, 2'b00, 32'd0, 32'd0};
    vt[1]  = '{mkex(OP_LBU, 32'h1003, 1'b1, 1'b1), 32'h80112233, 32'h00000080, 1'b1, 2'b00, 32'd0, 32'd0};
    vt[2]  = '{mkex(OP_LH,  32'h1002, 1'b1, 1'b1), 32'h80017FFF, 32'hFFFF8001, 1'b1, 2'b00, 32'd0, 32'd0};
    vt[3]  = '{mkex(OP_LHU, 32'h1002, 1'b1, 1'b1), 32'h80017FFF, 32'h00008001, 1'b1, 2'b00, 32'd0, 32'd0};
    vt[4]  = '{mkex(OP_LW,  32'h1000, 1'b1, 1'b1), 32'h80017FFF, 32'h80017FFF, 1'b1, 2'b00, 32'd0, 32'd0};
    vt[5]  = '{mkex(OP_LB,  32'h2001, 1'b1, 1'b1), 32'h00009F00, 32'hFFFFFF9F, 1'b1, 2'b00, 32'd0, 32'd0};
    vt[6]  = '{mkex(OP_SPEC, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 64'h00000001_00000003),
               32'h0, 32'h0, 1'b0, 2'b11, 32'h1, 32'h3};
    vt[7]  = '{mkex(OP_SPEC, 32'h55, 1'b0, 1'b0, 1'b0, 2'b01), 32'h0, 32'h55, 1'b0, 2'b01, 32'h0, 32'h55};
    vt[8]  = '{mkex(OP_SPEC, 32'h77, 1'b0, 1'b0, 1'b0, 2'b10), 32'h0, 32'h77, 1'b0, 2'b10, 32'h77, 32'h0};
    vt[9]  = '{mkex(OP_SPEC, 32'h99, 1'b0, 1'b0, 1'b1, 2'b01, 64'h0000000A_0000000B),
               32'h0, 32'h99, 1'b0, 2'b11, 32'hA, 32'hB};
    vt[10] = '{mkex(OP_ADDIU, 32'h1234, 1'b0, 1'b1), 32'hFFFFFFFF, 32'h1234, 1'b1, 2'b00, 32'd0, 32'd0};
    vt[11] = '{mkex(OP_LHU, 32'h3000, 1'b1, 1'b1), 32'h1234F00D, 32'h0000F00D, 1'b1, 2'b00, 32'd0, 32'd0};

    for (int i = 0; i < 12; i++) begin
      apply(vt[i].ex, 6'd0, 32'd0, "tbl_in");
      adv();
      apply(nop, 6'd0, vt[i].rdata, "tbl_out");
      chk($sformatf("tbl%0d_wdata", i), {104'd0, o_wdata}, {104'd0, vt[i].e_wdata});
      chk($sformatf("tbl%0d_we", i),    {135'd0, o_we},    {135'd0, vt[i].e_we});
      chk($sformatf("tbl%0d_hwe", i),   {134'd0, o_hwe},   {134'd0, vt[i].e_hwe});
      chk($sformatf("tbl%0d_hi", i),    {104'd0, o_hi},    {104'd0, vt[i].e_hi});
      chk($sformatf("tbl%0d_lo", i),    {104'd0, o_lo},    {104'd0, vt[i].e_lo});
      adv();
    end

    // load held in MEM across a full stall while the SRAM output moves on
    apply(mkex(OP_LW, 32'h4000, 1'b1, 1'b1), 6'd0, 32'd0, "hold_in");
    adv();
    apply(nop, 6'b011000, 32'h11223344, "hold_c0");
    chk("hold_c0_wdata", {104'd0, o_wdata}, {104'd0, 32'h11223344});
    adv();
    for (int c = 1; c < 3; c++) begin
      apply(nop, 6'b011000, 32'hDEADBEEF, "hold_cn");
      chk($sformatf("hold_c%0d_wdata", c), {104'd0, o_wdata}, {104'd0, 32'h11223344});
      adv();
    end
    apply(nop, 6'd0, 32'hDEADBEEF, "hold_rel");
    chk("hold_rel_wdata", {104'd0, o_wdata}, {104'd0, 32'h11223344});
    adv();

    // EX->MEM stalled while MEM->WB runs: bubble
    apply(mkex(OP_SPEC, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 64'h5_6), 6'd0, 32'd0, "bub_in");
    adv();
    apply(mkex(OP_ADDIU, 32'h9, 1'b0, 1'b1), 6'b001000, 32'd0, "bub_pre");
    chk("bub_pre_hwe", {134'd0, o_hwe}, {134'd0, 2'b11});
    adv();
    apply(nop, 6'd0, 32'd0, "bub_out");
    chk("bub_we", {135'd0, o_we}, 136'd0);
    chk("bub_hwe", {134'd0, o_hwe}, 136'd0);
    adv();

    // misaligned word load
    apply(mkex(OP_LW, 32'h5002, 1'b1, 1'b1), 6'd0, 32'd0, "adel_in");
    adv();
    apply(nop, 6'd0, 32'hCAFEF00D, "adel_out");
`ifdef MEM_ADDR_CHECK_EN
    chk("adel_flag", {135'd0, mem_excp_adel}, {135'd0, 1'b1});
    chk("adel_we", {135'd0, o_we}, {135'd0, 1'b0});
`else
    chk("adel_flag", {135'd0, mem_excp_adel}, {135'd0, 1'b0});
    chk("adel_we", {135'd0, o_we}, {135'd0, 1'b1});
`endif
    adv();

    // asynchronous reset in mid-cycle, then a load right after release
    apply(mkex(OP_ADDIU, 32'hABCD, 1'b0, 1'b1), 6'd0, 32'd0, "rst_pre");
    adv();
    #1 rst = 1'b1;
    #1;
    m_bus = '0; m_hv = 1'b0; m_hold = 32'd0;
    chk("rst_mid_wb", mem_to_wb_bus, 136'd0);
    chk("rst_mid_id", {32'd0, mem_to_id_bus}, 136'd0);
    chk("rst_mid_isload", {135'd0, mem_is_load}, 136'd0);
    chk("rst_mid_adel", {135'd0, mem_excp_adel}, 136'd0);
    rst = 1'b0;
    apply(mkex(OP_LB, 32'h1003, 1'b1, 1'b1), 6'd0, 32'd0, "rst_ld_in");
    adv();
    apply(nop, 6'd0, 32'h80112233, "rst_ld_out");
    chk("rst_ld_wdata", {104'd0, o_wdata}, {104'd0, 32'hFFFFFF80});
    adv();

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [5:0] st;
      r = $urandom_range(0, 9);
      st = 6'($urandom);
      if (r < 6)       st[4:3] = 2'b00;
      else if (r < 8)  st[4:3] = 2'b11;
      else if (r == 8) st[4:3] = 2'b01;
      else             st[4:3] = 2'b10;
      apply(rand_ex(), st, $urandom, "rnd");
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
